// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK
// and emits per-cycle write enables and datapath mux selects.
module mc_ctrl #(
  parameter int unsigned ST_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [5:0]      op,
  input  logic [5:0]      func,
  input  logic            zero,
  output logic            PCWr,
  output logic            IRWr,
  output logic            MemRd,
  output logic            MemWr,
  output logic            RegDst,
  output logic            RegWr,
  output logic            MemtoReg,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ExtOp,
  output logic [4:0]      ALUctr,
  output logic [1:0]      PCSrc,
  output logic [ST_W-1:0] state,
  output logic            done,
  output logic            illegal
);

  typedef enum logic [ST_W-1:0] {
    FETCH   = 'd0,
    DECODE  = 'd1,
    EXE_R   = 'd2,
    EXE_I   = 'd3,
    MEM_ADR = 'd4,
    MEM_RD  = 'd5,
    MEM_WB  = 'd6,
    MEM_WR  = 'd7,
    BRANCH  = 'd8,
    JUMP    = 'd9,
    ALU_WB  = 'd10
  } state_t;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLL  = 6'b000000;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_SLT = 5'b00100;
  localparam logic [4:0] ALU_SLL = 5'b00101;

  state_t     cur, nxt;
  logic [4:0] r_ctr;
  logic       r_ok;

  always_ff @(posedge clk) begin
    if (rst) cur <= FETCH;
    else     cur <= nxt;
  end

  always_comb begin
    r_ctr = ALU_ADD;
    r_ok  = 1'b1;
    case (func)
      FN_ADDU: r_ctr = ALU_ADD;
      FN_SUBU: r_ctr = ALU_SUB;
      FN_AND:  r_ctr = ALU_AND;
      FN_OR:   r_ctr = ALU_OR;
      FN_SLT:  r_ctr = ALU_SLT;
      FN_SLL:  r_ctr = ALU_SLL;
      default: r_ok  = 1'b0;
    endcase
  end

  always_comb begin
    nxt      = FETCH;
    PCWr     = 1'b0;
    IRWr     = 1'b0;
    MemRd    = 1'b0;
    MemWr    = 1'b0;
    RegDst   = 1'b0;
    RegWr    = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ExtOp    = 2'b00;
    ALUctr   = ALU_ADD;
    PCSrc    = 2'b00;
    done     = 1'b0;
    illegal  = 1'b0;
    case (cur)
      FETCH: begin
        MemRd   = 1'b1;
        IRWr    = 1'b1;
        PCWr    = 1'b1;
        ALUSrcB = 2'b01;
        nxt     = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        ExtOp   = 2'b01;
        case (op)
          OP_R: begin
            if (r_ok) nxt = EXE_R;
            else begin
              illegal = 1'b1;
              done    = 1'b1;
            end
          end
          OP_ADDIU, OP_ORI, OP_LUI: nxt = EXE_I;
          OP_LW, OP_SW:             nxt = MEM_ADR;
          OP_BEQ:                   nxt = BRANCH;
          OP_J:                     nxt = JUMP;
          default: begin
            illegal = 1'b1;
            done    = 1'b1;
          end
        endcase
      end
      EXE_R: begin
        ALUSrcA = 1'b1;
        ALUctr  = r_ctr;
        nxt     = ALU_WB;
      end
      EXE_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (op)
          OP_ORI: begin
            ExtOp  = 2'b00;
            ALUctr = ALU_OR;
          end
          OP_LUI:  ExtOp = 2'b10;
          default: ExtOp = 2'b01;
        endcase
        nxt = ALU_WB;
      end
      ALU_WB: begin
        RegWr  = 1'b1;
        RegDst = (op == OP_R);
        done   = 1'b1;
      end
      MEM_ADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ExtOp   = 2'b01;
        if (op == OP_LW)      nxt = MEM_RD;
        else if (op == OP_SW) nxt = MEM_WR;
      end
      MEM_RD: begin
        MemRd = 1'b1;
        nxt   = MEM_WB;
      end
      MEM_WB: begin
        RegWr    = 1'b1;
        MemtoReg = 1'b1;
        done     = 1'b1;
      end
      MEM_WR: begin
        MemWr = 1'b1;
        done  = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUctr  = ALU_SUB;
        PCSrc   = 2'b01;
        PCWr    = zero;
        done    = 1'b1;
      end
      JUMP: begin
        PCSrc = 2'b10;
        PCWr  = 1'b1;
        done  = 1'b1;
      end
      default: nxt = FETCH;
    endcase
    // Reset overrides the decode so an in-flight write never reaches the datapath.
    if (rst) begin
      PCWr     = 1'b0;
      IRWr     = 1'b0;
      MemRd    = 1'b0;
      MemWr    = 1'b0;
      RegDst   = 1'b0;
      RegWr    = 1'b0;
      MemtoReg = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = '0;
      ExtOp    = '0;
      ALUctr   = '0;
      PCSrc    = '0;
      done     = 1'b0;
      illegal  = 1'b0;
    end
  end

  assign state = rst ? '0 : cur;

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control unit that sequences the existing MIPS datapath over FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states. It replaces the single-cycle decoder when the datapath is rebuilt with IR, A/B, ALUOut and MDR registers and one shared memory port.
- Driven by the opcode/func fields of the held instruction register and the ALU zero flag.
- Emits per-cycle write enables and mux selects.

Parameters:
- ST_W, 4, width of the state register (11 states used)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- op  input  6  instruction[31:26] from IR
- func  input  6  instruction[5:0] from IR
- zero  input  1  ALU zero flag, valid in BRANCH state
- PCWr  output  1  PC write enable
- IRWr  output  1  IR write enable
- MemRd  output  1  memory read strobe
- MemWr  output  1  memory write strobe
- RegDst  output  1  1 = rd, 0 = rt
- RegWr  output  1  register file write enable
- MemtoReg  output  1  1 = MDR, 0 = ALUOut to register file
- ALUSrcA  output  1  0 = PC, 1 = A
- ALUSrcB  output  2  00 = B, 01 = const 4, 10 = ext imm, 11 = ext imm<<2
- ExtOp  output  2  00 = zero-ext, 01 = sign-ext, 10 = imm<<16
- ALUctr  output  5  00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 SLT, 00101 SLL
- PCSrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- state  output  ST_W  current state, for debug
- done  output  1  one-cycle pulse on the last cycle of each instruction
- illegal  output  1  one-cycle pulse in DECODE on an unsupported op/func

Behaviour:
- Supported instructions:
  - R-type (op 000000): addu 100001, subu 100011, and 100100, or 100101, slt 101010, sll 000000.
  - addiu 001001, ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010.
- States: FETCH 0, DECODE 1, EXE_R 2, EXE_I 3, MEM_ADR 4, MEM_RD 5, MEM_WB 6, MEM_WR 7, BRANCH 8, JUMP 9, ALU_WB 10.
- Outputs are combinational from state, op and func.
- Every output not listed for a state is 0, except ALUSrcB, ExtOp, ALUctr and PCSrc, which default to 00/00/ADD/00.
- FETCH: MemRd=1, IRWr=1, PCWr=1, ALUSrcA=0, ALUSrcB=01, ALUctr=ADD, PCSrc=00. Next state DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ExtOp=01, ALUctr=ADD (branch target into ALUOut).
  - Next state by op: R-type -> EXE_R; addiu/ori/lui -> EXE_I; lw/sw -> MEM_ADR; beq -> BRANCH; j -> JUMP.
  - Any other op, or an R-type with an unlisted func: illegal=1, done=1, next state FETCH, no write enables asserted.
- EXE_R: ALUSrcA=1, ALUSrcB=00, ALUctr decoded from func. Next state ALU_WB.
- EXE_I: ALUSrcA=1, ALUSrcB=10.
  - addiu: ExtOp=01, ADD.
  - ori: ExtOp=00, OR.
  - lui: ExtOp=10, ADD with A forced by the datapath to zero (rs=0 in the encoding).
  - Next state ALU_WB.
- ALU_WB: RegWr=1, MemtoReg=0, RegDst=1 if op=000000 else 0, done=1. Next state FETCH.
- MEM_ADR: ALUSrcA=1, ALUSrcB=10, ExtOp=01, ADD. lw -> MEM_RD; sw -> MEM_WR.
- MEM_RD: MemRd=1. Next state MEM_WB.
- MEM_WB: RegWr=1, MemtoReg=1, RegDst=0, done=1. Next state FETCH.
- MEM_WR: MemWr=1, done=1. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCSrc=01, PCWr=zero, done=1. Next state FETCH.
- JUMP: PCSrc=10, PCWr=1, done=1. Next state FETCH.
- Cycle counts per instruction: R-type and I-ALU 4; lw 5; sw 4; beq 3; j 3; illegal 2.
- Reset:
  - While rst=1, all outputs are forced to 0 (including done and illegal) and state is loaded to FETCH on the edge.
  - The first cycle after rst deasserts is FETCH.
  - Reset asserted in any state, including MEM_WR or MEM_WB, suppresses that cycle's writes. No partial instruction resumes.
- Unused state encodings (11-15) go to FETCH on the next edge with all outputs 0.
- The controller never stalls; memory is single-cycle.

Test Plan:
- Reset: hold rst 2 cycles, then release -> state=0, all outputs 0 during reset; first cycle after release shows IRWr=PCWr=MemRd=1, ALUSrcB=01.
- addu (op 000000, func 100001) -> states 0,1,2,10. In state 2, ALUctr=00000 and ALUSrcA=1. In state 10, RegWr=1, RegDst=1, done=1.
- lw (op 100011) -> states 0,1,4,5,6. In state 4, ExtOp=01 and ALUSrcB=10. In state 5, MemRd=1. In state 6, RegWr=1, MemtoReg=1, RegDst=0.
- beq (op 000100):
  - with zero=1 -> states 0,1,8, and PCWr=1, PCSrc=01, ALUctr=00001 in state 8.
  - with zero=0 -> PCWr=0 in state 8.
- Illegal: op 111111, then R-type with func 111111 -> illegal=1 and done=1 in DECODE, next state 0, RegWr=MemWr=PCWr=0 throughout.
- Reset mid-sw: assert rst while in state 7 -> MemWr=0 in that cycle, state=0 next cycle, no write observed by memory.
